ds_link_rx: RTL

IEEE 1355 DS-link receiver: the decode end of the node's d_out/s_out transmit path. It oversamples d_in/s_in on the system clock and recovers bits from transitions of d^s. It aligns on the first NULL, decodes data and control characters, checks odd parity, and detects disconnect. It has no backpressure; link flow control is carried by FCTs reported upward to the node's credit logic.

---
 rtl/ds_link_rx_pkg.sv | 21 ++
 rtl/ds_link_rx_if.sv | 36 +++
 rtl/ds_link_rx_bitrec.sv | 41 ++++
 rtl/ds_link_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ds_link_rx_pkg.sv
// Shared constants and state encoding for the DS-link receiver.
package ds_pkg;

  localparam logic [1:0] CTRL_FCT  = 2'b00;
  localparam logic [1:0] CTRL_EOP1 = 2'b01;
  localparam logic [1:0] CTRL_EOP2 = 2'b10;
  localparam logic [1:0] CTRL_ESC  = 2'b11;

  localparam int DATA_BITS = 8;
  localparam int CTRL_BITS = 2;

  // Last seven bits of ESC+FCT in arrival order (ESC parity bit is don't-care).
  localparam logic [6:0] NULL_PAT = 7'b1110100;

  typedef enum logic [1:0] {
    S_HUNT     = 2'd0,
    S_RUN      = 2'd1,
    S_ESC_PEND = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ds_link_rx_if.sv
// Line pins and decoded-character outputs of the DS-link receiver.
// Optional statistics counters are present when DS_LINK_RX_STATS_EN is defined.
interface ds_link_rx_if;
  import ds_pkg::*;

  logic                 d_in;
  logic                 s_in;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_eop;
  logic                 rx_eep;
  logic                 fct_rcvd;
  logic                 null_rcvd;
  logic                 got_null;
  logic                 par_err;
  logic                 esc_err;
  logic                 disc_err;
`ifdef DS_LINK_RX_STATS_EN
  logic [15:0]          char_cnt;
  logic [7:0]           err_cnt;

  modport master (input d_in, s_in,
                  output rx_valid, rx_data, rx_eop, rx_eep, fct_rcvd, null_rcvd,
                         got_null, par_err, esc_err, disc_err, char_cnt, err_cnt);
  modport slave  (output d_in, s_in,
                  input rx_valid, rx_data, rx_eop, rx_eep, fct_rcvd, null_rcvd,
                        got_null, par_err, esc_err, disc_err, char_cnt, err_cnt);
`else
  modport master (input d_in, s_in,
                  output rx_valid, rx_data, rx_eop, rx_eep, fct_rcvd, null_rcvd,
                         got_null, par_err, esc_err, disc_err);
  modport slave  (output d_in, s_in,
                  input rx_valid, rx_data, rx_eop, rx_eep, fct_rcvd, null_rcvd,
                        got_null, par_err, esc_err, disc_err);
`endif
endinterface

// File: rtl/ds_link_rx_bitrec.sv
// DS bit recovery: synchronises d/s and emits one registered bit per d^s transition.
module ds_rx_bitrec #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  input  logic i_s,
  output logic o_bit_vld,
  output logic o_bit_val
);

  logic [SYNC_STAGES-1:0] r_d_sync;
  logic [SYNC_STAGES-1:0] r_s_sync;
  logic                   r_ds_q;
  logic                   r_bit_vld;
  logic                   r_bit_val;
  logic                   w_ds;

  assign w_ds = r_d_sync[SYNC_STAGES-1] ^ r_s_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_sync  <= '0;
      r_s_sync  <= '0;
      r_ds_q    <= 1'b0;
      r_bit_vld <= 1'b0;
      r_bit_val <= 1'b0;
    end else begin
      r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], i_d};
      r_s_sync  <= {r_s_sync[SYNC_STAGES-2:0], i_s};
      r_ds_q    <= w_ds;
      r_bit_vld <= w_ds ^ r_ds_q;
      r_bit_val <= r_d_sync[SYNC_STAGES-1];
    end
  end

  assign o_bit_vld = r_bit_vld;
  assign o_bit_val = r_bit_val;

endmodule

// File: rtl/ds_link_rx.sv
// IEEE 1355 DS-link receiver: NULL alignment, character decode, parity and disconnect detection.
// Define DS_LINK_RX_STATS_EN to add saturating char_cnt/err_cnt outputs.
module ds_link_rx
  import ds_pkg::*;
#(
  parameter int DISC_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input logic          clk,
  input logic          rst_n,
  ds_link_rx_if.master bus
);

  localparam int              CNT_W         = $clog2(DISC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DISC_TIMEOUT - 1);
  localparam logic [3:0]      POS_DATA_LAST = 4'(DATA_BITS + 1);
  localparam logic [3:0]      POS_CTRL_LAST = 4'(CTRL_BITS + 1);

  logic w_bit_vld, w_bit_val;

  ds_rx_bitrec #(.SYNC_STAGES(SYNC_STAGES)) u_bitrec (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_d       (bus.d_in),
    .i_s       (bus.s_in),
    .o_bit_vld (w_bit_vld),
    .o_bit_val (w_bit_val)
  );

  rx_state_e            r_state;
  logic [5:0]           r_win;
  logic [3:0]           r_pos;
  logic                 r_isctl, r_prev_par;
  logic [6:0]           r_pay;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_armed;
  logic                 r_rx_valid, r_rx_eop, r_rx_eep, r_fct, r_null;
  logic                 r_gn, r_par, r_esc, r_disc;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_p;

  logic [DATA_BITS-1:0] w_data;
  logic [1:0]           w_ctl;
  logic                 w_last, w_par_ok, w_disc, w_err;
  logic w_ev_null_hunt, w_ev_null_run, w_ev_par, w_ev_esc;
  logic w_ev_data, w_ev_eop, w_ev_eep, w_ev_fct, w_ev_escstart;

  // Payload shifts in LSB first; control codes are written in arrival order.
  assign w_data   = {w_bit_val, r_pay};
  assign w_ctl    = {r_pay[6], w_bit_val};
  assign w_last   = r_isctl ? (r_pos == POS_CTRL_LAST) : (r_pos == POS_DATA_LAST);
  assign w_par_ok = r_prev_par ^ r_p ^ w_bit_val;
  assign w_disc   = r_armed && !w_bit_vld && (r_cnt == CNT_LAST);
  assign w_err    = w_ev_par | w_ev_esc | w_disc;

  always_comb begin
    w_ev_null_hunt = 1'b0;
    w_ev_null_run  = 1'b0;
    w_ev_par       = 1'b0;
    w_ev_esc       = 1'b0;
    w_ev_data      = 1'b0;
    w_ev_eop       = 1'b0;
    w_ev_eep       = 1'b0;
    w_ev_fct       = 1'b0;
    w_ev_escstart  = 1'b0;
    if (r_state == S_HUNT) begin
      w_ev_null_hunt = w_bit_vld && ({r_win, w_bit_val} == NULL_PAT);
    end else if (w_bit_vld && r_pos == 4'd1) begin
      w_ev_par = !w_par_ok;
    end else if (w_bit_vld && r_pos >= 4'd2 && w_last) begin
      if (r_state == S_ESC_PEND) begin
        if (r_isctl && w_ctl == CTRL_FCT) w_ev_null_run = 1'b1;
        else                              w_ev_esc      = 1'b1;
      end else if (!r_isctl) begin
        w_ev_data = 1'b1;
      end else begin
        case (w_ctl)
          CTRL_FCT:  w_ev_fct      = 1'b1;
          CTRL_EOP1: w_ev_eop      = 1'b1;
          CTRL_EOP2: w_ev_eep      = 1'b1;
          default:   w_ev_escstart = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_HUNT;
      r_win      <= '0;
      r_pos      <= '0;
      r_isctl    <= 1'b0;
      r_prev_par <= 1'b0;
      r_p        <= 1'b0;
      r_pay      <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_eop   <= 1'b0;
      r_rx_eep   <= 1'b0;
      r_fct      <= 1'b0;
      r_null     <= 1'b0;
      r_gn       <= 1'b0;
      r_par      <= 1'b0;
      r_esc      <= 1'b0;
      r_disc     <= 1'b0;
    end else begin
      r_rx_valid <= w_ev_data | w_ev_eop | w_ev_eep;
      r_rx_eop   <= w_ev_eop;
      r_rx_eep   <= w_ev_eep;
      r_fct      <= w_ev_fct;
      r_null     <= w_ev_null_hunt | w_ev_null_run;
      r_par      <= w_ev_par;
      r_esc      <= w_ev_esc;
      r_disc     <= w_disc;
      if (w_ev_data) r_rx_data <= w_data;

      if (w_err)               r_gn <= 1'b0;
      else if (w_ev_null_hunt) r_gn <= 1'b1;

      // The disconnect counter only runs once a bit has been seen since reset or the last error.
      if (w_bit_vld)                r_cnt <= '0;
      else if (r_armed && !w_disc)  r_cnt <= r_cnt + 1'b1;
      if (w_err)          r_armed <= 1'b0;
      else if (w_bit_vld) r_armed <= 1'b1;

      if (w_err) begin
        r_state <= S_HUNT;
        r_win   <= '0;
        r_pos   <= '0;
      end else if (w_bit_vld) begin
        if (r_state == S_HUNT) begin
          r_win <= {r_win[4:0], w_bit_val};
          if (w_ev_null_hunt) begin
            r_state    <= S_RUN;
            r_prev_par <= 1'b0;
            r_pos      <= '0;
          end
        end else if (r_pos == 4'd0) begin
          r_p   <= w_bit_val;
          r_pos <= 4'd1;
        end else if (r_pos == 4'd1) begin
          r_isctl <= w_bit_val;
          r_pos   <= 4'd2;
        end else begin
          r_pay <= w_data[DATA_BITS-1:1];
          if (w_last) begin
            r_pos      <= '0;
            r_prev_par <= ^(r_isctl ? {6'd0, w_ctl} : w_data);
            if (w_ev_escstart)     r_state <= S_ESC_PEND;
            else if (w_ev_null_run) r_state <= S_RUN;
          end else begin
            r_pos <= r_pos + 4'd1;
          end
        end
      end
    end
  end

  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_eop    = r_rx_eop;
  assign bus.rx_eep    = r_rx_eep;
  assign bus.fct_rcvd  = r_fct;
  assign bus.null_rcvd = r_null;
  assign bus.got_null  = r_gn;
  assign bus.par_err   = r_par;
  assign bus.esc_err   = r_esc;
  assign bus.disc_err  = r_disc;

`ifdef DS_LINK_RX_STATS_EN
  logic [15:0] r_char_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_char_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if ((w_ev_data | w_ev_eop | w_ev_eep) && r_char_cnt != '1) r_char_cnt <= r_char_cnt + 16'd1;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.char_cnt = r_char_cnt;
  assign bus.err_cnt  = r_err_cnt;
`endif

endmodule
